// File: rtl/mux_pkg.sv
// mux_pkg: shared state encoding, width helper and default sizes for the scanning mux
package mux_pkg;
   typedef enum logic {IDLE, SCAN} state_t;
   localparam int DEF_N = 8;
   localparam int DEF_W = 1;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/mux_scan_n_if.sv
// mux_scan_n_if: channel bank, control and valid/ready output bundle of mux_scan_n
interface mux_scan_n_if import mux_pkg::*; #(parameter int N = DEF_N, parameter int W = DEF_W);
   localparam int SELW = clog2(N);
   logic [N*W-1:0] in_data;
   logic mode;
   logic [SELW-1:0] sel;
   logic start;
   logic [N-1:0] ch_mask;
   logic [W-1:0] out_data;
   logic [SELW-1:0] out_ch;
   logic out_valid;
   logic out_ready;
   logic busy;
   logic done;
   modport master (output in_data, mode, sel, start, ch_mask, out_ready,
                   input out_data, out_ch, out_valid, busy, done);
   modport slave (input in_data, mode, sel, start, ch_mask, out_ready,
                  output out_data, out_ch, out_valid, busy, done);
endinterface

// File: rtl/mux_out_reg.sv
// mux_out_reg: valid/ready holding register for one data+channel beat
module mux_out_reg #(parameter int W = 1, parameter int SELW = 3) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic [W-1:0] d_data,
   input  logic [SELW-1:0] d_ch,
   input  logic ready,
   output logic [W-1:0] q_data,
   output logic [SELW-1:0] q_ch,
   output logic valid,
   output logic free
);
   assign free = !valid || ready;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_data <= '0;
         q_ch <= '0;
         valid <= 1'b0;
      end else if (free) begin
         valid <= load;
         if (load) begin
            q_data <= d_data;
            q_ch <= d_ch;
         end
      end
   end
endmodule

// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel registered mux with manual select and handshaked scan; MUX_SCAN_SKIP_EN skips masked channels
module mux_scan_n import mux_pkg::*; #(parameter int N = DEF_N, parameter int W = DEF_W) (
   input logic clk,
   input logic rst_n,
   mux_scan_n_if.slave bus
);
   localparam int SELW = clog2(N);
   localparam logic [SELW-1:0] LAST = SELW'(N - 1);
   state_t state;
   logic [SELW-1:0] ptr, idx;
   logic [N-1:0][W-1:0] chans;
   logic [W-1:0] d_data;
   logic free, emit, load, step, last, pend;
   assign chans = bus.in_data;
`ifdef MUX_SCAN_SKIP_EN
   assign emit = bus.ch_mask[ptr];
`else
   logic unused_mask;
   assign unused_mask = ^bus.ch_mask;
   assign emit = 1'b1;
`endif
   // a skipped channel needs no register slot, so the pointer may advance while stalled
   always_comb begin
      idx = state == SCAN ? ptr : bus.sel;
      d_data = idx <= LAST ? chans[idx] : '0;
      load = free && (state == SCAN ? emit : !bus.mode);
      step = state == SCAN && (free || !emit);
      last = step && ptr == LAST;
   end
   mux_out_reg #(.W(W), .SELW(SELW)) u_out (
      .clk(clk),
      .rst_n(rst_n),
      .load(load),
      .d_data(d_data),
      .d_ch(idx),
      .ready(bus.out_ready),
      .q_data(bus.out_data),
      .q_ch(bus.out_ch),
      .valid(bus.out_valid),
      .free(free)
   );
   // pend: scan finished, done waits until the final beat leaves the register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr <= '0;
         pend <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         if (state == IDLE && bus.mode && bus.start) begin
            state <= SCAN;
            ptr <= '0;
            bus.busy <= 1'b1;
         end else if (step) begin
            ptr <= last ? '0 : ptr + 1'b1;
            state <= last ? IDLE : SCAN;
            bus.busy <= !last;
         end
         if (last) begin
            pend <= emit || !free;
            bus.done <= !emit && free;
         end else begin
            pend <= pend && !free;
            bus.done <= pend && free;
         end
      end
   end
endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed checks of manual mode, scan, back-pressure, masking, N=5 and mid-scan reset
module tb_mux_scan_n;
   logic clk, rst_n;
   int n_cmp, n_bad;
   logic [7:0] exp_a;
   logic [3:0] exp_b [5];
   mux_scan_n_if #(.N(8), .W(1)) a_if ();
   mux_scan_n_if #(.N(5), .W(4)) b_if ();
   mux_scan_n #(.N(8), .W(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
   mux_scan_n #(.N(5), .W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick;
      tick;
      n_cmp++; if (a_if.out_data !== 1'b0) begin n_bad++; $display("FAIL reset_data got %b want 0", a_if.out_data); end
      n_cmp++; if (a_if.out_ch !== 3'd0) begin n_bad++; $display("FAIL reset_ch got %0d want 0", a_if.out_ch); end
      n_cmp++; if (a_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", a_if.out_valid); end
      n_cmp++; if (a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done got %b%b want 00", a_if.busy, a_if.done); end
      n_cmp++; if (b_if.out_valid !== 1'b0 || b_if.out_data !== 4'h0) begin n_bad++; $display("FAIL reset_b got v=%b d=%h want v=0 d=0", b_if.out_valid, b_if.out_data); end
      rst_n = 1'b1;
   endtask

   task automatic test_manual;
      a_if.mode = 1'b0;
      a_if.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         a_if.sel = 3'(k);
         tick;
         n_cmp++;
         if (a_if.out_data !== exp_a[k] || a_if.out_ch !== 3'(k) || a_if.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL manual_sel%0d got d=%b ch=%0d v=%b want d=%b ch=%0d v=1", k, a_if.out_data, a_if.out_ch, a_if.out_valid, exp_a[k], k);
         end
      end
   endtask

   task automatic test_scan;
      a_if.out_ready = 1'b1;
      a_if.mode = 1'b1;
      a_if.start = 1'b1;
      tick;
      a_if.start = 1'b0;
      n_cmp++; if (a_if.busy !== 1'b1 || a_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL scan_start got busy=%b v=%b want busy=1 v=0", a_if.busy, a_if.out_valid); end
      for (int k = 0; k < 8; k++) begin
         tick;
         n_cmp++;
         if (a_if.out_valid !== 1'b1 || a_if.out_ch !== 3'(k) || a_if.out_data !== exp_a[k] || a_if.busy !== (k < 7) || a_if.done !== 1'b0) begin
            n_bad++;
            $display("FAIL scan_beat%0d got v=%b ch=%0d d=%b busy=%b done=%b want v=1 ch=%0d d=%b busy=%b done=0",
                     k, a_if.out_valid, a_if.out_ch, a_if.out_data, a_if.busy, a_if.done, k, exp_a[k], k < 7);
         end
      end
      tick;
      n_cmp++; if (a_if.done !== 1'b1 || a_if.out_valid !== 1'b0 || a_if.busy !== 1'b0) begin n_bad++; $display("FAIL scan_done got done=%b v=%b busy=%b want 1 0 0", a_if.done, a_if.out_valid, a_if.busy); end
      tick;
      n_cmp++; if (a_if.done !== 1'b0) begin n_bad++; $display("FAIL scan_done_width got %b want 0", a_if.done); end
   endtask

   task automatic test_backpressure;
      int nb, nd;
      bit stalled;
      logic [2:0] hch;
      logic hd;
      nb = 0; nd = 0; stalled = 0; hch = '0; hd = 1'b0;
      a_if.out_ready = 1'b1;
      a_if.mode = 1'b1;
      a_if.start = 1'b1;
      tick;
      a_if.start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (a_if.done === 1'b1) nd++;
         if (stalled) begin
            n_cmp++;
            if (a_if.out_valid !== 1'b1 || a_if.out_ch !== hch || a_if.out_data !== hd) begin
               n_bad++;
               $display("FAIL bp_hold got v=%b ch=%0d d=%b want v=1 ch=%0d d=%b", a_if.out_valid, a_if.out_ch, a_if.out_data, hch, hd);
            end
            stalled = 0;
         end
         a_if.out_ready = (c % 2 == 0);
         if (a_if.out_valid === 1'b1) begin
            if (a_if.out_ready) begin
               n_cmp++;
               if (nb >= 8 || a_if.out_ch !== 3'(nb) || a_if.out_data !== exp_a[nb[2:0]]) begin
                  n_bad++;
                  $display("FAIL bp_beat%0d got ch=%0d d=%b", nb, a_if.out_ch, a_if.out_data);
               end
               nb++;
            end else begin
               stalled = 1;
               hch = a_if.out_ch;
               hd = a_if.out_data;
            end
         end
         tick;
      end
      a_if.out_ready = 1'b1;
      n_cmp++; if (nb != 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", nb); end
      n_cmp++; if (nd != 1) begin n_bad++; $display("FAIL bp_done got %0d want 1", nd); end
      n_cmp++; if (a_if.busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy got %b want 0", a_if.busy); end
   endtask

   task automatic test_mask;
      int nb, nd, nv, dk;
      logic [2:0] exp_ch [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
      nb = 0; nd = 0; nv = 0; dk = 0;
      a_if.out_ready = 1'b1;
      a_if.mode = 1'b1;
      a_if.ch_mask = 8'b10100101;
      a_if.start = 1'b1;
      tick;
      a_if.start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick;
         if (a_if.done === 1'b1) nd++;
         if (a_if.out_valid === 1'b1) begin
            n_cmp++;
`ifdef MUX_SCAN_SKIP_EN
            if (nb >= 4 || a_if.out_ch !== exp_ch[nb] || a_if.out_data !== exp_a[exp_ch[nb]]) begin
`else
            if (nb >= 8 || a_if.out_ch !== 3'(nb) || a_if.out_data !== exp_a[nb[2:0]]) begin
`endif
               n_bad++;
               $display("FAIL mask_beat%0d got ch=%0d d=%b", nb, a_if.out_ch, a_if.out_data);
            end
            nb++;
         end
      end
`ifdef MUX_SCAN_SKIP_EN
      n_cmp++; if (nb != 4) begin n_bad++; $display("FAIL mask_count got %0d want 4", nb); end
`else
      n_cmp++; if (nb != 8) begin n_bad++; $display("FAIL mask_count got %0d want 8", nb); end
`endif
      n_cmp++; if (nd != 1) begin n_bad++; $display("FAIL mask_done got %0d want 1", nd); end
`ifdef MUX_SCAN_SKIP_EN
      a_if.ch_mask = 8'h00;
      a_if.start = 1'b1;
      tick;
      a_if.start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick;
         if (a_if.out_valid === 1'b1) nv++;
         if (a_if.done === 1'b1 && dk == 0) dk = k;
      end
      n_cmp++; if (nv != 0) begin n_bad++; $display("FAIL mask0_beats got %0d want 0", nv); end
      n_cmp++; if (dk != 8) begin n_bad++; $display("FAIL mask0_done_cycle got %0d want 8", dk); end
`endif
      a_if.ch_mask = 8'hFF;
   endtask

   task automatic test_n5;
      int nb, nd;
      nb = 0; nd = 0;
      b_if.out_ready = 1'b1;
      b_if.mode = 1'b1;
      b_if.start = 1'b1;
      tick;
      b_if.start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick;
         if (b_if.done === 1'b1) nd++;
         if (b_if.out_valid === 1'b1) begin
            n_cmp++;
            if (nb >= 5 || b_if.out_ch !== 3'(nb) || b_if.out_data !== exp_b[nb]) begin
               n_bad++;
               $display("FAIL n5_beat%0d got ch=%0d d=%h", nb, b_if.out_ch, b_if.out_data);
            end
            nb++;
         end
      end
      n_cmp++; if (nb != 5) begin n_bad++; $display("FAIL n5_count got %0d want 5", nb); end
      n_cmp++; if (nd != 1) begin n_bad++; $display("FAIL n5_done got %0d want 1", nd); end
      b_if.mode = 1'b0;
      b_if.sel = 3'd6;
      tick;
      n_cmp++; if (b_if.out_data !== 4'h0 || b_if.out_ch !== 3'd6 || b_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL n5_sel6 got d=%h ch=%0d v=%b want d=0 ch=6 v=1", b_if.out_data, b_if.out_ch, b_if.out_valid); end
      b_if.sel = 3'd4;
      tick;
      n_cmp++; if (b_if.out_data !== 4'h9 || b_if.out_ch !== 3'd4) begin n_bad++; $display("FAIL n5_sel4 got d=%h ch=%0d want d=9 ch=4", b_if.out_data, b_if.out_ch); end
   endtask

   task automatic test_reset_mid;
      int nb, nd, nv;
      nb = 0; nd = 0; nv = 0;
      a_if.out_ready = 1'b1;
      a_if.mode = 1'b1;
      a_if.start = 1'b1;
      tick;
      a_if.start = 1'b0;
      for (int k = 0; k < 4; k++) tick;
      n_cmp++; if (a_if.out_ch !== 3'd3 || a_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_beat3 got ch=%0d v=%b want ch=3 v=1", a_if.out_ch, a_if.out_valid); end
      rst_n = 1'b0;
      tick;
      n_cmp++;
      if (a_if.out_data !== 1'b0 || a_if.out_ch !== 3'd0 || a_if.out_valid !== 1'b0 || a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin
         n_bad++;
         $display("FAIL rmid_reset got d=%b ch=%0d v=%b busy=%b done=%b want all 0", a_if.out_data, a_if.out_ch, a_if.out_valid, a_if.busy, a_if.done);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick;
         if (a_if.done === 1'b1) nd++;
         if (a_if.out_valid === 1'b1) nv++;
      end
      n_cmp++; if (nd != 0 || nv != 0) begin n_bad++; $display("FAIL rmid_quiet got done=%0d beats=%0d want 0 0", nd, nv); end
      nd = 0;
      a_if.start = 1'b1;
      tick;
      a_if.start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick;
         if (a_if.done === 1'b1) nd++;
         if (a_if.out_valid === 1'b1) begin
            n_cmp++;
            if (nb >= 8 || a_if.out_ch !== 3'(nb)) begin n_bad++; $display("FAIL rmid_rescan%0d got ch=%0d", nb, a_if.out_ch); end
            nb++;
         end
      end
      n_cmp++; if (nb != 8 || nd != 1) begin n_bad++; $display("FAIL rmid_rescan_total got beats=%0d done=%0d want 8 1", nb, nd); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      exp_a = 8'b00101101;
      exp_b = '{4'h3, 4'hA, 4'h5, 4'hC, 4'h9};
      rst_n = 1'b0;
      a_if.in_data = 8'b00101101;
      a_if.mode = 1'b0;
      a_if.sel = '0;
      a_if.start = 1'b0;
      a_if.ch_mask = 8'hFF;
      a_if.out_ready = 1'b1;
      b_if.in_data = 20'h9C5A3;
      b_if.mode = 1'b0;
      b_if.sel = '0;
      b_if.start = 1'b0;
      b_if.ch_mask = 5'h1F;
      b_if.out_ready = 1'b1;
      test_reset;
      test_manual;
      test_scan;
      test_backpressure;
      test_mask;
      test_n5;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
